video_timing: RTL and testbench

VIDEO_TIMING -- requirements
Module: video_timing

---
 rtl/video_timing.sv | 114 +++++++++++
 tb/tb_video_timing.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// video_timing: raster timing generator for a pixel-clocked display.
// A free-running (h, v) position walks active, front porch, sync and
// back porch on each axis. Every enabled clock registers sync/de/x/y/marker
// outputs for the current position and then advances it, so the outputs
// lag the internal position by exactly one enabled clock.
module video_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned X_BITS   = 10,
  parameter int unsigned Y_BITS   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              line_start,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam logic [X_BITS-1:0] H_LAST = X_BITS'(H_TOTAL - 1);
  localparam logic [Y_BITS-1:0] V_LAST = Y_BITS'(V_TOTAL - 1);

  // Refuse to elaborate when a full line or frame cannot be counted.
  if (H_TOTAL == 0 || ((H_TOTAL - 1) >> X_BITS) != 0) begin : g_h_range
    $error("video_timing: H_TOTAL does not fit in X_BITS");
  end
  if (V_TOTAL == 0 || ((V_TOTAL - 1) >> Y_BITS) != 0) begin : g_v_range
    $error("video_timing: V_TOTAL does not fit in Y_BITS");
  end

  logic [X_BITS-1:0] h;
  logic [Y_BITS-1:0] v;

  logic [X_BITS-1:0] h_next_c;
  logic [Y_BITS-1:0] v_next_c;
  logic              h_wrap_c;
  logic              de_c;
  logic              hs_act_c;
  logic              vs_act_c;
  logic              line_start_c;
  logic              frame_start_c;

  // Next position and region decode of the current position.
  // Compares run at 32 bits so a region ending exactly at 2**X_BITS still works.
  always_comb begin
    h_wrap_c      = 1'b0;
    h_next_c      = h;
    v_next_c      = v;
    de_c          = 1'b0;
    hs_act_c      = 1'b0;
    vs_act_c      = 1'b0;
    line_start_c  = 1'b0;
    frame_start_c = 1'b0;

    h_wrap_c = (h == H_LAST);
    if (h_wrap_c) begin
      h_next_c = '0;
      v_next_c = (v == V_LAST) ? '0 : v + Y_BITS'(1);
    end else begin
      h_next_c = h + X_BITS'(1);
    end

    de_c          = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    hs_act_c      = (32'(h) >= H_SYNC_START) && (32'(h) < H_SYNC_END);
    vs_act_c      = (32'(v) >= V_SYNC_START) && (32'(v) < V_SYNC_END);
    line_start_c  = (h == '0);
    frame_start_c = (h == '0) && (v == '0);
  end

  // Register outputs for the current position, then step the position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h           <= '0;
      v           <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= !HS_POL;
      vsync       <= !VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      x           <= h;
      y           <= v;
      de          <= de_c;
      hsync       <= hs_act_c ? HS_POL : !HS_POL;
      vsync       <= vs_act_c ? VS_POL : !VS_POL;
      line_start  <= line_start_c;
      frame_start <= frame_start_c;
      h           <= h_next_c;
      v           <= v_next_c;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing with a small raster (8x6 total, active-high syncs).
// The reference treats the output stream as a count of enabled edges since
// reset and derives position and region flags from it arithmetically.
module tb_video_timing;

  localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       hsync, vsync, de, line_start, frame_start;
  logic [9:0] x, y;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned k = 0;   // enabled edges since last reset release

  video_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .X_BITS(10), .Y_BITS(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (k=%0d t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  // Compare every output against the arithmetic reference for the current k.
  task automatic check_model();
    int unsigned pos, h, v;
    logic e_hs, e_vs, e_de, e_ls, e_fs;
    if (k == 0) begin
      h = 0; v = 0; e_hs = 0; e_vs = 0; e_de = 0; e_ls = 0; e_fs = 0;
    end else begin
      pos  = k - 1;
      h    = pos % HT;
      v    = (pos / HT) % VT;
      e_de = (h < HA) && (v < VA);
      e_hs = (h >= HA + HF) && (h < HA + HF + HS);
      e_vs = (v >= VA + VF) && (v < VA + VF + VS);
      e_ls = (h == 0);
      e_fs = (pos % (HT * VT)) == 0;
    end
    check("x", 32'(x), h);
    check("y", 32'(y), v);
    check("de", 32'(de), 32'(e_de));
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("line_start", 32'(line_start), 32'(e_ls));
    check("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  // Called around a negedge: drive en, take one posedge, check at the next negedge.
  task automatic tick(input logic en_v);
    en = en_v;
    @(posedge clk);
    if (rst_n && en_v) k++;
    @(negedge clk);
    check_model();
  endtask

  // Asynchronous reset pulse placed entirely within the low clock phase.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    k = 0;
    #1 check_model();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Held reset: outputs stay at reset values through clocks with any en.
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 check_model();
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous enable across a full frame plus one wrap.
    for (int e = 1; e <= 49; e++) begin
      tick(1'b1);
      if (e == 1) begin
        check("e1_fs", 32'(frame_start), 1);
        check("e1_ls", 32'(line_start), 1);
        check("e1_de", 32'(de), 1);
        check("e1_xy", {x, 6'd0, y}, 0);
      end
      if (e == 5) check("e5_de", 32'(de), 0);
      if (e == 6 || e == 7) check("line_hsync", 32'(hsync), 1);
      if (e == 8) check("e8_hsync", 32'(hsync), 0);
      if (e == 9) begin
        check("e9_ls", 32'(line_start), 1);
        check("e9_y", 32'(y), 1);
      end
      if (e == 32) check("e32_vsync", 32'(vsync), 0);
      if (e == 33 || e == 40) check("frame_vsync", 32'(vsync), 1);
      if (e == 41) check("e41_vsync", 32'(vsync), 0);
      if (e == 48) begin
        check("e48_x", 32'(x), 7);
        check("e48_y", 32'(y), 5);
      end
      if (e == 49) begin
        check("e49_x", 32'(x), 0);
        check("e49_y", 32'(y), 0);
        check("e49_fs", 32'(frame_start), 1);
      end
    end

    // Enable pause after the second edge holds everything.
    pulse_reset();
    tick(1'b1);
    tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      check("hold_x", 32'(x), 1);
      check("hold_de", 32'(de), 1);
      check("hold_fs", 32'(frame_start), 0);
    end
    tick(1'b1);
    check("resume_x", 32'(x), 2);

    // Mid-frame asynchronous reset at x=5, y=2.
    pulse_reset();
    while (k < 22) tick(1'b1);
    check("pre_rst_x", 32'(x), 5);
    check("pre_rst_y", 32'(y), 2);
    pulse_reset();
    check("rst_x", 32'(x), 0);
    check("rst_hsync", 32'(hsync), 0);
    tick(1'b1);
    check("post_rst_y", 32'(y), 0);
    check("post_rst_fs", 32'(frame_start), 1);

    // Random enable pattern with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else tick($urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
